fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
- Sequencing controller for the fetch stage.
- Each cycle it decides whether the PC advances and which of four PC sources it loads: PC+4, npc, EPC or the exception vector.
- Arbitrates redirect requests from D (branch/jump, eret) and from CP0 (interrupt/exception), holds requests that arrive during a hazard stall, and generates pipeline flushes.
- Tracks the branch-delay-slot flag of the instruction in D for CP0.

Parameters:
ERET_FLUSH, 1, 1 = the instruction fetched in the eret redirect cycle is squashed (flush_D); 0 = no flush.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  hazard-unit stall of PC and F/D register
br_req  in  1  one-cycle pulse: D-stage branch/jump taken; npc held valid by D until redirect issued
is_branch_D  in  1  instruction currently in D is a branch/jump
eret_req  in  1  one-cycle pulse: eret decoded in D; EPC stable until redirect issued
int_req  in  1  interrupt/exception request from CP0 (level)
m_valid  in  1  M stage holds a real instruction (not a bubble)
pc_en  out  1  PC write enable
pc_src  out  2  0 = PC+4, 1 = npc, 2 = EPC, 3 = vector 0x4180
flush_D  out  1  clear F/D register
flush_E  out  1  clear D/E register
flush_M  out  1  clear E/M register
bd_D  out  1  instruction in D is a delay slot
exc_taken  out  1  one-cycle pulse on exception entry
state_o  out  2  current FSM state (debug)

Behaviour:
- FSM states: RUN=0, PEND_BR=1, PEND_ERET=2. pend_int is a separate sticky flag.
- Outputs are Mealy: combinational from state, pend_int and inputs. State, pend_int and bd_D are registered.
- Reset: state=RUN, pend_int=0, bd_D=0.
  - Outputs during reset cycle: pc_en=1, pc_src=0, all flushes=0, exc_taken=0.
- Priority, evaluated each cycle: exception > eret > branch > sequential.
- Exception:
  - eff_int = int_req | pend_int.
  - If eff_int & m_valid: pc_src=3, pc_en=1 (stall ignored), flush_D=flush_E=flush_M=1, exc_taken=1.
  - Next state=RUN; pend_int cleared; any pending branch/eret discarded; bd_D cleared.
  - If int_req & !m_valid: pend_int set and the cycle proceeds as if int_req=0. Exception entry waits for a valid M instruction.
- RUN, no exception:
  - eret_req & !stall: pc_src=2, pc_en=1, flush_D=ERET_FLUSH.
  - eret_req & stall: pc_en=0, next=PEND_ERET.
  - br_req & !stall: pc_src=1, pc_en=1.
  - br_req & stall: pc_en=0, next=PEND_BR.
  - Otherwise: pc_src=0, pc_en=!stall.
  - eret_req and br_req together: eret wins, br_req ignored.
- PEND_BR / PEND_ERET:
  - pc_en=0 while stall=1.
  - First cycle with stall=0: issue the held redirect exactly as in RUN (src 1, or src 2 plus ERET_FLUSH), then next=RUN.
  - New br_req/eret_req pulses while pending are ignored (protocol violation).
  - An exception taken while pending overrides and clears it.
- bd_D:
  - Any flush_D: bd_D <= 0.
  - Else if pc_en & !stall (F/D advances): bd_D <= is_branch_D.
  - Else: hold.
  - The delay slot is never squashed by a branch redirect. Only exception or eret flush clears it.
- Only one redirect is ever pending (single-entry hold). No queueing.
- exc_taken is high for exactly one cycle per exception entry.

Test Plan:
1. Reset then 3 idle cycles (stall=0, no requests) -> pc_en=1, pc_src=0 every cycle, flushes=0, state_o=0, bd_D=0.
2. is_branch_D=1 with br_req pulse, stall=0 -> same cycle pc_src=1, pc_en=1. Next cycle bd_D=1, pc_src=0.
3. br_req pulse while stall=1, stall held 3 cycles -> state_o=1 and pc_en=0 for 3 cycles. Cycle stall falls: pc_src=1, pc_en=1. Then state_o=0.
4. eret_req and br_req same cycle, stall=0, ERET_FLUSH=1 -> pc_src=2, flush_D=1, branch dropped (next cycle pc_src=0). Repeat with ERET_FLUSH=0 -> flush_D=0.
5. int_req pulse with m_valid=0 for 2 cycles, then m_valid=1 -> pend_int holds and normal fetch continues. Then pc_src=3, pc_en=1, all flushes=1, exc_taken=1 for one cycle, bd_D=0.
6. State PEND_ERET with stall=1, int_req=1, m_valid=1 -> exception taken despite stall (pc_en=1, pc_src=3). state_o returns to 0 and the eret is never issued. Reset asserted mid-PEND_BR -> state_o=0 next cycle.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage sequencing: picks the next-PC source, holds redirects that hit a
// hazard stall, takes exceptions and tracks the delay-slot flag of the D instruction.
module fetch_redirect_ctrl #(
   parameter bit ERET_FLUSH = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       stall,
   input  logic       br_req,
   input  logic       is_branch_D,
   input  logic       eret_req,
   input  logic       int_req,
   input  logic       m_valid,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       flush_D,
   output logic       flush_E,
   output logic       flush_M,
   output logic       bd_D,
   output logic       exc_taken,
   output logic [1:0] state_o
);

   localparam logic [1:0] RUN       = 2'd0;
   localparam logic [1:0] PEND_BR   = 2'd1;
   localparam logic [1:0] PEND_ERET = 2'd2;

   localparam logic [1:0] SRC_SEQ  = 2'd0;
   localparam logic [1:0] SRC_NPC  = 2'd1;
   localparam logic [1:0] SRC_EPC  = 2'd2;
   localparam logic [1:0] SRC_VEC  = 2'd3;

   logic [1:0] state, state_nxt;
   logic       pend_int, pend_int_nxt;
   logic       exc;

   // Exception entry waits until M holds a real instruction to report as EPC.
   assign exc = (int_req | pend_int) & m_valid;

   always_comb begin
      state_nxt    = state;
      pend_int_nxt = pend_int;
      pc_en        = !stall;
      pc_src       = SRC_SEQ;
      flush_D      = 1'b0;
      flush_E      = 1'b0;
      flush_M      = 1'b0;
      exc_taken    = 1'b0;

      if (reset) begin
         pc_en        = 1'b1;
         state_nxt    = RUN;
         pend_int_nxt = 1'b0;
      end else if (exc) begin
         pc_en        = 1'b1;
         pc_src       = SRC_VEC;
         flush_D      = 1'b1;
         flush_E      = 1'b1;
         flush_M      = 1'b1;
         exc_taken    = 1'b1;
         state_nxt    = RUN;
         pend_int_nxt = 1'b0;
      end else begin
         if (int_req) pend_int_nxt = 1'b1;
         case (state)
            PEND_BR: begin
               if (stall) pc_en = 1'b0;
               else begin
                  pc_en     = 1'b1;
                  pc_src    = SRC_NPC;
                  state_nxt = RUN;
               end
            end
            PEND_ERET: begin
               if (stall) pc_en = 1'b0;
               else begin
                  pc_en     = 1'b1;
                  pc_src    = SRC_EPC;
                  flush_D   = ERET_FLUSH;
                  state_nxt = RUN;
               end
            end
            default: begin
               state_nxt = RUN;
               if (eret_req) begin
                  if (stall) begin
                     pc_en     = 1'b0;
                     state_nxt = PEND_ERET;
                  end else begin
                     pc_en   = 1'b1;
                     pc_src  = SRC_EPC;
                     flush_D = ERET_FLUSH;
                  end
               end else if (br_req) begin
                  if (stall) begin
                     pc_en     = 1'b0;
                     state_nxt = PEND_BR;
                  end else begin
                     pc_en  = 1'b1;
                     pc_src = SRC_NPC;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         pend_int <= 1'b0;
         bd_D     <= 1'b0;
      end else begin
         state    <= state_nxt;
         pend_int <= pend_int_nxt;
         // A branch redirect never squashes its delay slot; only flushes clear it.
         if (flush_D)              bd_D <= 1'b0;
         else if (pc_en && !stall) bd_D <= is_branch_D;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: two instances cover both ERET_FLUSH settings.
module tb_fetch_redirect_ctrl;

   logic clk = 1'b0;
   logic reset, stall, br_req, is_branch_D, eret_req, int_req, m_valid;
   logic       pc_en0, flush_D0, flush_E0, flush_M0, bd_D0, exc_taken0;
   logic [1:0] pc_src0, state0;
   logic       pc_en1, flush_D1, flush_E1, flush_M1, bd_D1, exc_taken1;
   logic [1:0] pc_src1, state1;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   fetch_redirect_ctrl #(.ERET_FLUSH(1'b1)) u0 (
      .clk(clk), .reset(reset), .stall(stall), .br_req(br_req),
      .is_branch_D(is_branch_D), .eret_req(eret_req), .int_req(int_req),
      .m_valid(m_valid), .pc_en(pc_en0), .pc_src(pc_src0), .flush_D(flush_D0),
      .flush_E(flush_E0), .flush_M(flush_M0), .bd_D(bd_D0),
      .exc_taken(exc_taken0), .state_o(state0));

   fetch_redirect_ctrl #(.ERET_FLUSH(1'b0)) u1 (
      .clk(clk), .reset(reset), .stall(stall), .br_req(br_req),
      .is_branch_D(is_branch_D), .eret_req(eret_req), .int_req(int_req),
      .m_valid(m_valid), .pc_en(pc_en1), .pc_src(pc_src1), .flush_D(flush_D1),
      .flush_E(flush_E1), .flush_M(flush_M1), .bd_D(bd_D1),
      .exc_taken(exc_taken1), .state_o(state1));

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Applies inputs just after the rising edge; checks follow 3 time units later.
   task automatic drive(input logic r, input logic s, input logic br, input logic ib,
                        input logic er, input logic ir, input logic mv);
      @(posedge clk);
      #1;
      reset = r; stall = s; br_req = br; is_branch_D = ib;
      eret_req = er; int_req = ir; m_valid = mv;
      #3;
   endtask

   // Checks pc_en, pc_src, {flush_D,flush_E,flush_M}, exc_taken, state_o, bd_D of u0.
   task automatic chk_all(input string tag, input logic en, input logic [1:0] src,
                          input logic [2:0] fl, input logic ex, input logic [1:0] st,
                          input logic bd);
      chk({tag, ".pc_en"},  {3'b0, pc_en0}, {3'b0, en});
      chk({tag, ".pc_src"}, {2'b0, pc_src0}, {2'b0, src});
      chk({tag, ".flush"},  {1'b0, flush_D0, flush_E0, flush_M0}, {1'b0, fl});
      chk({tag, ".exc"},    {3'b0, exc_taken0}, {3'b0, ex});
      chk({tag, ".state"},  {2'b0, state0}, {2'b0, st});
      chk({tag, ".bd_D"},   {3'b0, bd_D0}, {3'b0, bd});
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; br_req = 1'b0; is_branch_D = 1'b0;
      eret_req = 1'b0; int_req = 1'b0; m_valid = 1'b0;

      // Reset cycle outputs
      drive(1, 0, 0, 0, 0, 0, 0);
      chk({"rst", ".pc_en"},  {3'b0, pc_en0}, 4'd1);
      chk({"rst", ".pc_src"}, {2'b0, pc_src0}, 4'd0);
      chk({"rst", ".flush"},  {1'b0, flush_D0, flush_E0, flush_M0}, 4'd0);
      chk({"rst", ".exc"},    {3'b0, exc_taken0}, 4'd0);

      // 1: idle
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0);
         chk_all("idle", 1, 0, 3'b000, 0, 0, 0);
      end

      // 2: unstalled branch, delay slot flagged next cycle
      drive(0, 0, 1, 1, 0, 0, 0);
      chk_all("br", 1, 1, 3'b000, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk_all("br_ds", 1, 0, 3'b000, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk_all("br_after", 1, 0, 3'b000, 0, 0, 0);

      // 3: branch under stall is held then issued
      drive(0, 1, 1, 0, 0, 0, 0);
      chk_all("brst_req", 0, 0, 3'b000, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, 0, 0, 0);
         chk_all("brst_hold", 0, 0, 3'b000, 0, 1, 0);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      chk_all("brst_issue", 1, 1, 3'b000, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk_all("brst_done", 1, 0, 3'b000, 0, 0, 0);

      // 4: eret beats branch; flush_D follows ERET_FLUSH
      drive(0, 0, 1, 0, 1, 0, 0);
      chk_all("eret", 1, 2, 3'b100, 0, 0, 0);
      chk("eret_nf.flush_D", {3'b0, flush_D1}, 4'd0);
      chk("eret_nf.pc_src",  {2'b0, pc_src1}, 4'd2);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk_all("eret_after", 1, 0, 3'b000, 0, 0, 0);
      chk("eret_nf_after.pc_src", {2'b0, pc_src1}, 4'd0);

      // 5: interrupt held pending until M is valid
      drive(0, 0, 0, 0, 0, 1, 0);
      chk_all("int_pend0", 1, 0, 3'b000, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0);
      chk_all("int_pend1", 1, 0, 3'b000, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 1);
      chk_all("int_take", 1, 3, 3'b111, 1, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 1);
      chk_all("int_after", 1, 0, 3'b000, 0, 0, 0);

      // 6: exception overrides a pending eret under stall
      drive(0, 1, 0, 0, 1, 0, 1);
      chk_all("pe_req", 0, 0, 3'b000, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 1);
      chk_all("pe_hold", 0, 0, 3'b000, 0, 2, 0);
      drive(0, 1, 0, 0, 0, 1, 1);
      chk_all("pe_exc", 1, 3, 3'b111, 1, 2, 0);
      drive(0, 0, 0, 0, 0, 0, 1);
      chk_all("pe_after", 1, 0, 3'b000, 0, 0, 0);

      // Reset while a branch is pending
      drive(0, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 0);
      chk_all("rpb_hold", 0, 0, 3'b000, 0, 1, 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      chk({"rpb_rst", ".pc_en"}, {3'b0, pc_en0}, 4'd1);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk_all("rpb_after", 1, 0, 3'b000, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
